// File: rtl/store_buffer.sv
// Store buffer sitting in front of data_memory: queues pipeline stores in a
// small circular FIFO, drains one per cycle into the memory write port, and
// forwards the youngest matching buffered store to loads so they never read
// stale memory contents.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 20,
  parameter int DW    = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_addr,
  output logic [DW-1:0]              ld_data,
  output logic                       ld_fwd,
  input  logic                       drain_hold,
  output logic [AW-1:0]              mem_write_address,
  output logic [DW-1:0]              mem_write_data,
  output logic                       mem_memwrite,
  output logic [AW-1:0]              mem_read_address,
  output logic                       mem_memread,
  input  logic [DW-1:0]              mem_read_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             push;
  logic             pop;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

  // Handshake and drain decisions come from registered state only, so a
  // full buffer stays not-ready even while its head entry is leaving.
  assign st_ready = (count_q != CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push     = st_valid & st_ready;
  assign pop      = ~empty & ~drain_hold;

  // The head entry is always presented to memory; memwrite qualifies it.
  assign mem_write_address = addr_q[rd_ptr_q];
  assign mem_write_data    = data_q[rd_ptr_q];
  assign mem_memwrite      = pop;

  assign mem_read_address  = ld_addr;
  assign mem_memread       = ld_valid;

  // Next-state for pointers, occupancy and valid bits; push and pop never
  // target the same slot because push needs a free slot and pop a used one.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset deliberately throws away undrained stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset since the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= st_addr;
      data_q[wr_ptr_q] <= st_data;
    end
  end

  // Forwarding search from oldest to youngest so the youngest match, the
  // slot just behind wr_ptr, overrides any older one; the draining head is
  // included because its write lands in memory only at the coming edge.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr_q - PW'(k);
      if (valid_q[idx] && (addr_q[idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  // Load result mux: buffered data wins over memory only for a valid load.
  always_comb begin
    ld_fwd  = ld_valid & fwd_hit;
    ld_data = ld_fwd ? fwd_data : mem_read_data;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-buffer stage directly upstream of data_memory, between the MEM pipeline stage and the memory write/read ports.
- Accepts stores from the pipeline into a small FIFO and drains one store per clock into data_memory's write port.
- Loads are routed to data_memory's read port. When a younger, not-yet-written store to the same address is still buffered, that store's data is forwarded to the load instead, so loads never see stale memory.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2
- AW, 20, address width
- DW, 20, data width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- st_valid  in  1  pipeline presents a store this cycle
- st_addr  in  AW  store address
- st_data  in  DW  store data
- st_ready  out  1  buffer can accept a store (count < DEPTH)
- ld_valid  in  1  pipeline presents a load this cycle
- ld_addr  in  AW  load address
- ld_data  out  DW  load result (combinational)
- ld_fwd  out  1  ld_data came from the buffer, not memory
- drain_hold  in  1  suppress draining this cycle
- mem_write_address  out  AW  to data_memory write_address
- mem_write_data  out  DW  to data_memory write_data
- mem_memwrite  out  1  to data_memory memwrite
- mem_read_address  out  AW  to data_memory read_address
- mem_memread  out  1  to data_memory memread
- mem_read_data  in  DW  from data_memory read_data
- count  out  clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

Behaviour:

Storage:
- Circular FIFO of DEPTH entries, each holding {valid, addr, data}.
- wr_ptr and rd_ptr are clog2(DEPTH) bits wide and wrap modulo DEPTH.

Reset (async, rst=1):
- wr_ptr=0, rd_ptr=0, count=0, all valid bits=0.
- Outputs: st_ready=1, empty=1, mem_memwrite=0, ld_fwd=0.
- An in-flight store or load is discarded.
- Buffered stores not yet drained are lost. This is intentional: reset aborts the program.

Enqueue:
- push = st_valid & st_ready.
- On posedge: entry[wr_ptr] = {1, st_addr, st_data}, then wr_ptr++.
- st_valid while full: the store is not accepted. The pipeline must stall on !st_ready and hold st_* stable.

Drain:
- pop = !empty & !drain_hold.
- Combinationally, every cycle: mem_write_address=entry[rd_ptr].addr, mem_write_data=entry[rd_ptr].data, mem_memwrite=pop.
- data_memory commits the write on the same posedge. On that edge the buffer clears entry[rd_ptr].valid and increments rd_ptr.
- Drain latency: a store accepted at edge N is written to memory at edge N+1 at the earliest.

Count:
- push only: count+1. Pop only: count-1. Both, or neither: count unchanged.
- st_ready = (count != DEPTH), from registered state only, with no same-cycle bypass.
- A full buffer with a pop in progress still reports st_ready=0 that cycle.

Load path (combinational):
- mem_read_address=ld_addr; mem_memread=ld_valid.
- Forwarding search runs over all valid entries, including the entry being drained this cycle; that entry's write is not yet visible in memory.
- Match condition is a full AW-bit address compare.
- On multiple matches, the youngest wins: closest behind wr_ptr, searching backwards with wrap.
- Hit: ld_fwd=1, ld_data=matched entry's data.
- Miss: ld_fwd=0, ld_data=mem_read_data.
- With ld_valid=0: ld_fwd=0 and ld_data=mem_read_data.
- A store presented in the same cycle as a load is not searched. The pipeline never issues both in one cycle; asserting both is a protocol violation and ld_data is unspecified.

Ordering:
- Stores drain strictly in acceptance order. Same-address stores are never merged.

Test Plan:
1. Reset mid-operation: 3 stores buffered, assert rst for 1 cycle -> count=0, empty=1, st_ready=1, mem_memwrite=0 immediately (async); the next load of a previously buffered address returns memory contents, ld_fwd=0.
2. Fill and drain: drain_hold=1; push (addr 5, 0x00011), (6, 0x00022), (7, 0x00033), (8, 0x00044) -> count=4, st_ready=0. A 5th store is held off. Release drain_hold -> memwrite for addr 5, 6, 7, 8 on 4 consecutive edges; then empty=1.
3. Forwarding, youngest wins: drain_hold=1; store (addr 14, 0x00001), then (addr 14, 0x000AA); load addr 14 -> ld_fwd=1, ld_data=0x000AA. Load addr 3 -> ld_fwd=0, ld_data=mem_read_data (0x00002 after init).
4. Forward during drain: one store (addr 9, 0x12345) buffered, drain_hold=0, load addr 9 in the drain cycle -> ld_fwd=1, ld_data=0x12345. Next cycle: ld_fwd=0, memory returns 0x12345.
5. Simultaneous push/pop: count=2, st_valid=1, drain active -> count stays 2, pointers advance by 1 each. Repeat for 2*DEPTH cycles to exercise wrap; the memory write order matches the push order exactly.
6. Full boundary: count=4 with pop active and st_valid=1 -> st_ready=0, no enqueue, count=3 after the edge. On the next cycle st_ready=1, the store is accepted, and count stays 3 if a pop also occurs.
